// File: rtl/dmux_issue_ctrl_pkg.sv
// Shared types and width helpers for the demux issue/collect stage.
package dmux_issue_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Select width leaves one spare code so an out-of-range index is representable.
  function automatic int f_sel_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int f_cnt_width(input int l);
    return $clog2(l + 1) + 1;
  endfunction

endpackage

// File: rtl/dmux_issue_skid.sv
// One-entry {sel,data} holding buffer; push_ready is registered so it never
// depends combinationally on the pushing side.
module dmux_issue_skid #(
  parameter int WIDTH = 1,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [SEL_W-1:0] push_sel,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             entry_valid,
  output logic [SEL_W-1:0] entry_sel,
  output logic [WIDTH-1:0] entry_data
);

  logic valid_next;
  logic load;

  assign load = push_valid && push_ready;

  always_comb begin
    valid_next = entry_valid;
    if (entry_valid && pop) begin
      valid_next = 1'b0;
    end else if (load) begin
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid <= 1'b0;
      push_ready  <= 1'b0;
      entry_sel   <= '0;
      entry_data  <= '0;
    end else begin
      entry_valid <= valid_next;
      push_ready  <= !valid_next;
      if (load) begin
        entry_sel  <= push_sel;
        entry_data <= push_data;
      end
    end
  end

endmodule

// File: rtl/dmux_issue_ctrl.sv
// Issue/collect stage for a fixed-latency demux: holds sel/data stable for
// LATENCY+1 clocks, captures the addressed lane and strobes its valid bit.
module dmux_issue_ctrl
  import dmux_issue_ctrl_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int OUTPUT_COUNT = 2,
  parameter int LATENCY      = 0,
  localparam int SEL_W       = f_sel_width(OUTPUT_COUNT),
  localparam int CNT_W       = f_cnt_width(LATENCY)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SEL_W-1:0]              s_sel,
  input  logic [WIDTH-1:0]              s_data,
  output logic [SEL_W-1:0]              dmux_sel,
  output logic [WIDTH-1:0]              dmux_in,
  input  logic [WIDTH*OUTPUT_COUNT-1:0] dmux_out,
  output logic [OUTPUT_COUNT-1:0]       m_valid,
  output logic [WIDTH*OUTPUT_COUNT-1:0] m_data,
  output logic                          busy,
  output logic                          err
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             in_range;
  logic             complete;
  logic             skid_push;
  logic             take_next;
  logic             next_valid;
  logic [SEL_W-1:0] next_sel;
  logic [WIDTH-1:0] next_data;
  logic             skid_valid;
  logic [SEL_W-1:0] skid_sel;
  logic [WIDTH-1:0] skid_data;

  assign accept    = s_valid && s_ready;
  assign in_range  = s_sel < SEL_W'(OUTPUT_COUNT);
  assign complete  = (state == ST_HOLD) && (cnt == CNT_W'(LATENCY));
  assign take_next = (state == ST_IDLE) || complete;
  // A request arriving mid-hold parks in the skid; on completion it bypasses.
  assign skid_push = accept && in_range && (state == ST_HOLD) && !complete;

  assign next_valid = skid_valid || (accept && in_range);
  assign next_sel   = skid_valid ? skid_sel  : s_sel;
  assign next_data  = skid_valid ? skid_data : s_data;
  assign busy       = (state == ST_HOLD);

  dmux_issue_skid #(
    .WIDTH(WIDTH),
    .SEL_W(SEL_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (skid_push),
    .push_ready (s_ready),
    .push_sel   (s_sel),
    .push_data  (s_data),
    .pop        (take_next),
    .entry_valid(skid_valid),
    .entry_sel  (skid_sel),
    .entry_data (skid_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dmux_sel <= '0;
      dmux_in  <= '0;
      m_valid  <= '0;
      err      <= 1'b0;
    end else begin
      err     <= accept && !in_range;
      m_valid <= complete ? (OUTPUT_COUNT'(1) << dmux_sel) : '0;
      case (state)
        ST_IDLE: begin
          if (next_valid) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            dmux_sel <= next_sel;
            dmux_in  <= next_data;
          end
        end
        ST_HOLD: begin
          if (complete) begin
            cnt <= '0;
            if (next_valid) begin
              dmux_sel <= next_sel;
              dmux_in  <= next_data;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < OUTPUT_COUNT; gi++) begin : g_lane
    logic [WIDTH-1:0] lane_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_reg <= '0;
      end else if (complete && (dmux_sel == SEL_W'(gi))) begin
        lane_reg <= dmux_out[gi*WIDTH +: WIDTH];
      end
    end
    assign m_data[gi*WIDTH +: WIDTH] = lane_reg;
  end

endmodule
